// File: rtl/dmem_responder_if.sv
// Request/response bundle for one data-memory port.
// master: requester (core side) drives valid/instr/addr/wdata/wstrb.
// slave : memory side returns the ready pulse and rdata.
interface dmem_responder_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/dmem_responder.sv
// Two-port data-memory responder over a single-port word array.
// Each port owns a one-deep pending register; an arbiter grants one port
// whenever the array is idle, and the response (ready pulse + rdata) comes
// back LATENCY cycles after the grant on the originating port.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   dmem0/dmem1  request/response bundles (slave side)
// Parameters: DEPTH (words, power of two, >= 16), LATENCY (1..4).
// Build option: define DMEM_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority.
module dmem_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave dmem0,
  dmem_responder_if.slave dmem1
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Request inputs gathered per port
  logic [1:0]    req_vld;
  logic [AW-1:0] req_idx   [2];
  logic [DW-1:0] req_wdata [2];
  logic [SW-1:0] req_wstrb [2];

  assign req_vld      = {dmem1.valid, dmem0.valid};
  assign req_idx[0]   = dmem0.addr[AW+1:2];
  assign req_idx[1]   = dmem1.addr[AW+1:2];
  assign req_wdata[0] = dmem0.wdata;
  assign req_wdata[1] = dmem1.wdata;
  assign req_wstrb[0] = dmem0.wstrb;
  assign req_wstrb[1] = dmem1.wstrb;

  // Fetch tag and address bits outside the word index carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{dmem0.instr, dmem1.instr,
                         dmem0.addr[DW-1:AW+2], dmem0.addr[1:0],
                         dmem1.addr[DW-1:AW+2], dmem1.addr[1:0]};

  logic [1:0]    pend_q, pend_d;
  logic [AW-1:0] idx_q   [2];
  logic [AW-1:0] idx_d   [2];
  logic [DW-1:0] wdata_q [2];
  logic [DW-1:0] wdata_d [2];
  logic [SW-1:0] wstrb_q [2];
  logic [SW-1:0] wstrb_d [2];
  logic [BW-1:0] busy_q, busy_d;
  logic [1:0]    gnt;
  logic          gsel;
  logic [AW-1:0] g_idx;
  logic [DW-1:0] g_wdata;
  logic [SW-1:0] g_wstrb;
  logic          g_wr;
  logic [DW-1:0] g_rdata;
  logic [DW-1:0] mem [DEPTH];

`ifdef DMEM_RR_EN
  logic rr_q, rr_d;  // 1: port 1 wins the next conflict
`endif

  // Arbiter: one grant per idle array cycle
  always_comb begin
    gnt = 2'b00;
    if (busy_q == '0) begin
      if (pend_q == 2'b11) begin
`ifdef DMEM_RR_EN
        gnt = rr_q ? 2'b10 : 2'b01;
`else
        gnt = 2'b01;
`endif
      end else begin
        gnt = pend_q;
      end
    end
  end

  assign gsel    = gnt[1];
  assign g_idx   = idx_q[gsel];
  assign g_wdata = wdata_q[gsel];
  assign g_wstrb = wstrb_q[gsel];
  assign g_wr    = |g_wstrb;
  assign g_rdata = g_wr ? '0 : mem[g_idx];

  // Next state: pending capture/clear and array busy countdown
  always_comb begin
    pend_d = pend_q;
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      idx_d[p]   = idx_q[p];
      wdata_d[p] = wdata_q[p];
      wstrb_d[p] = wstrb_q[p];
    end
`ifdef DMEM_RR_EN
    rr_d = rr_q;
    if (|gnt) rr_d = gnt[0];
`endif
    if (|gnt) begin
      busy_d = BW'(LATENCY - 1);
    end else if (busy_q != '0) begin
      busy_d = busy_q - BW'(1);
    end
    // A request seen while pend is still set (including the grant cycle) is dropped
    for (int p = 0; p < 2; p++) begin
      if (gnt[p]) begin
        pend_d[p] = 1'b0;
      end else if (req_vld[p] && !pend_q[p]) begin
        pend_d[p]  = 1'b1;
        idx_d[p]   = req_idx[p];
        wdata_d[p] = req_wdata[p];
        wstrb_d[p] = req_wstrb[p];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      busy_q <= '0;
      for (int p = 0; p < 2; p++) begin
        idx_q[p]   <= '0;
        wdata_q[p] <= '0;
        wstrb_q[p] <= '0;
      end
`ifdef DMEM_RR_EN
      rr_q <= 1'b0;
`endif
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      for (int p = 0; p < 2; p++) begin
        idx_q[p]   <= idx_d[p];
        wdata_q[p] <= wdata_d[p];
        wstrb_q[p] <= wstrb_d[p];
      end
`ifdef DMEM_RR_EN
      rr_q <= rr_d;
`endif
    end
  end

  // Byte-masked array write at the end of the grant cycle; array is never cleared
  always_ff @(posedge clock) begin
    if (|gnt && g_wr) begin
      for (int b = 0; b < SW; b++) begin
        if (g_wstrb[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
      end
    end
  end

  // Response pipe: the last stage is the per-port output register
  logic          out_vld;
  logic          out_port;
  logic [DW-1:0] out_data;

  if (LATENCY == 1) begin : g_nopipe
    assign out_vld  = |gnt;
    assign out_port = gsel;
    assign out_data = g_rdata;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q;
    logic [LATENCY-2:0] pp_q;
    logic [DW-1:0]      pd_q [LATENCY-1];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pv_q <= '0;
        pp_q <= '0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) pd_q[i] <= '0;
      end else begin
        pv_q[0] <= |gnt;
        pp_q[0] <= gsel;
        pd_q[0] <= g_rdata;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
          pp_q[i] <= pp_q[i-1];
          pd_q[i] <= pd_q[i-1];
        end
      end
    end

    assign out_vld  = pv_q[LATENCY-2];
    assign out_port = pp_q[LATENCY-2];
    assign out_data = pd_q[LATENCY-2];
  end

  logic [1:0]    ready_q;
  logic [DW-1:0] rdata_q [2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      ready_q[0] <= out_vld && !out_port;
      ready_q[1] <= out_vld && out_port;
      rdata_q[0] <= (out_vld && !out_port) ? out_data : '0;
      rdata_q[1] <= (out_vld && out_port) ? out_data : '0;
    end
  end

  assign dmem0.ready = ready_q[0];
  assign dmem0.rdata = rdata_q[0];
  assign dmem1.ready = ready_q[1];
  assign dmem1.rdata = rdata_q[1];
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=16, LATENCY=2) against a
// timestamp/queue model of the responder's behaviour.
module tb_dmem_responder;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
`ifdef DMEM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock (clk),
    .reset (rst_n),
    .dmem0 (if0),
    .dmem1 (if1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; int port; logic [31:0] data; } resp_t;
  resp_t       rq[$];
  logic [31:0] mm [DEPTH];
  bit          mp [2];
  int          mi [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  int          ecnt = 0;
  int          free_at = 0;
  int          last_g = 1;
  logic        er [2];
  logic [31:0] ed [2];

  always @(posedge clk) begin : model
    bit          ps [2];
    logic        vi [2];
    logic [31:0] ai [2];
    logic [31:0] wi [2];
    logic [3:0]  si [2];
    int          g;
    ecnt++;
    er[0] = 1'b0; er[1] = 1'b0; ed[0] = '0; ed[1] = '0;
    vi[0] = if0.valid; ai[0] = if0.addr; wi[0] = if0.wdata; si[0] = if0.wstrb;
    vi[1] = if1.valid; ai[1] = if1.addr; wi[1] = if1.wdata; si[1] = if1.wstrb;
    if (!rst_n) begin
      mp[0] = 1'b0; mp[1] = 1'b0;
      rq.delete();
      free_at = 0;
      last_g  = 1;
    end else begin
      ps = mp;
      g  = -1;
      if (ecnt >= free_at && (mp[0] || mp[1])) begin
        if (mp[0] && mp[1]) g = (RR && last_g == 0) ? 1 : 0;
        else                g = mp[0] ? 0 : 1;
        last_g  = g;
        free_at = ecnt + LAT;
        if (ms[g] == 4'h0) begin
          rq.push_back('{ecnt + LAT - 1, g, mm[mi[g]]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (ms[g][b]) mm[mi[g]][b*8 +: 8] = mw[g][b*8 +: 8];
          rq.push_back('{ecnt + LAT - 1, g, 32'h0});
        end
        mp[g] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (vi[p] === 1'b1 && !ps[p]) begin
          mp[p] = 1'b1;
          mi[p] = int'((ai[p] >> 2) % 32'(DEPTH));
          mw[p] = wi[p];
          ms[p] = si[p];
        end
      end
      for (int i = 0; i < rq.size(); i++) begin
        if (rq[i].due == ecnt) begin
          er[rq[i].port] = 1'b1;
          ed[rq[i].port] = rq[i].data;
          rq.delete(i);
          break;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst ready0", 32'(if0.ready), 32'h0);
      chk("rst ready1", 32'(if1.ready), 32'h0);
      chk("rst rdata0", if0.rdata, 32'h0);
      chk("rst rdata1", if1.rdata, 32'h0);
    end else begin
      chk("ready0", 32'(if0.ready), 32'(er[0]));
      chk("ready1", 32'(if1.ready), 32'(er[1]));
      chk("rdata0", if0.rdata, ed[0]);
      chk("rdata1", if1.rdata, ed[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    if (p == 0) begin
      if0.valid = v; if0.instr = 1'b0; if0.addr = a; if0.wdata = wd; if0.wstrb = st;
    end else begin
      if1.valid = v; if1.instr = 1'b0; if1.addr = a; if1.wdata = wd; if1.wstrb = st;
    end
  endtask

  task automatic issue_now(input int p, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
    drive(p, 1'b1, a, wd, st);
    @(posedge clk); #1;
    drive(p, 1'b0, '0, '0, '0);
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st);
    @(posedge clk); #1;
    issue_now(p, a, wd, st);
  endtask

  task automatic wait_rdy(input int p, output int lat, output logic [31:0] d);
    lat = -1; d = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((p == 0 ? if0.ready : if1.ready) === 1'b1) begin
        lat = k;
        d = (p == 0) ? if0.rdata : if1.rdata;
        break;
      end
    end
  endtask

  task automatic wait_both(output int k0, output int k1,
                           output logic [31:0] d0, output logic [31:0] d1);
    k0 = -1; k1 = -1; d0 = '0; d1 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (if0.ready === 1'b1 && k0 < 0) begin k0 = k; d0 = if0.rdata; end
      if (if1.ready === 1'b1 && k1 < 0) begin k1 = k; d1 = if1.rdata; end
      if (k0 > 0 && k1 > 0) break;
    end
  endtask

  task automatic conflict_read(output int k0, output int k1,
                               output logic [31:0] d0, output logic [31:0] d1);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h10, '0, 4'h0);
    drive(1, 1'b1, 32'h20, '0, 4'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    wait_both(k0, k1, d0, d1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    int          lat, k0, k1, cnt;
    logic [31:0] d, d0, d1, first;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready0 literal", 32'(if0.ready), 32'h0);
    chk("reset rdata1 literal", if1.rdata, 32'h0);
    rst_n = 1'b1;

    // Give every word a known value before anything reads it
    for (int i = 0; i < DEPTH; i++) issue(i % 2, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
    repeat (6) @(posedge clk);

    // Write then re-issued read in the ready cycle
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rdy(0, lat, d);
    chk("write latency", 32'(lat), 32'd3);
    chk("write rdata zero", d, 32'h0);
    issue_now(0, 32'h10, '0, 4'h0);
    wait_rdy(0, lat, d);
    chk("read latency", 32'(lat), 32'd3);
    chk("read data", d, 32'hDEADBEEF);
    chk("model word 0x10", mm[4], 32'hDEADBEEF);

    // Byte strobes
    issue(0, 32'h20, 32'h11223344, 4'hF); wait_rdy(0, lat, d);
    issue(0, 32'h20, 32'hAABBCCDD, 4'h5); wait_rdy(0, lat, d);
    issue(0, 32'h20, '0, 4'h0);           wait_rdy(0, lat, d);
    chk("byte strobe merge", d, 32'h11BB33DD);
    chk("model word 0x20", mm[8], 32'h11BB33DD);

    // Wrap-around modulo DEPTH*4 bytes
    issue(1, 32'h40, 32'h5A5A5A5A, 4'hF); wait_rdy(1, lat, d);
    issue(1, 32'h00, '0, 4'h0);           wait_rdy(1, lat, d);
    chk("wrap read data", d, 32'h5A5A5A5A);
    chk("wrap read latency", 32'(lat), 32'd3);

    // Conflict after a port-1 grant: port 0 first in both builds
    conflict_read(k0, k1, d0, d1);
    chk("conflict1 lat0", 32'(k0), 32'd3);
    chk("conflict1 lat1", 32'(k1), 32'd5);
    chk("conflict1 data0", d0, 32'hDEADBEEF);
    chk("conflict1 data1", d1, 32'h11BB33DD);

    // Conflict after a port-0 grant: round-robin flips the order
    issue(0, 32'h10, '0, 4'h0); wait_rdy(0, lat, d);
    conflict_read(k0, k1, d0, d1);
    chk("conflict2 lat0", 32'(k0), RR ? 32'd5 : 32'd3);
    chk("conflict2 lat1", 32'(k1), RR ? 32'd3 : 32'd5);

    // Protocol violation: second request while pend=1 is dropped
    repeat (4) @(posedge clk);
    #1 drive(0, 1'b1, 32'h10, '0, 4'h0);
    @(posedge clk); #1 drive(0, 1'b1, 32'h20, '0, 4'h0);
    @(posedge clk); #1 drive(0, 1'b0, '0, '0, '0);
    cnt = 0; first = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if0.ready === 1'b1) begin
        if (cnt == 0) first = if0.rdata;
        cnt++;
      end
    end
    chk("violation pulse count", 32'(cnt), 32'd1);
    chk("violation data", first, 32'hDEADBEEF);

    // Reset in the grant cycle of a read
    issue(0, 32'h10, '0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if0.ready === 1'b1) cnt++;
    end
    chk("no ready after reset", 32'(cnt), 32'd0);
    issue(0, 32'h10, '0, 4'h0); wait_rdy(0, lat, d);
    chk("array kept over reset", d, 32'hDEADBEEF);

    // Randomized traffic on both ports
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        drive(p, ($urandom_range(0, 2) == 0), $urandom(), $urandom(),
              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (12) @(posedge clk);
    #1;
    chk("model queue drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
